// File: rtl/cpu4_pkg.sv
// Shared cpu4 definitions: opcode constants and instruction-sequencer state encoding.
package cpu4_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_LOAD  = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_NOT   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_JMP   = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Presented on the issue fields whenever no instruction is being offered.
   localparam logic [11:0] NOP_WORD = {OP_HALT, 4'h0, 4'h0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_GAP,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/cpu4_prog_mem.sv
// Program store for the cpu4 sequencer: DEPTH x 12 bits, one write port, registered read.
module cpu4_prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [11:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [11:0]   rd_data
);

   logic [11:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cpu4_instr_sequencer.sv
// Loads a small program, then issues it word by word to the cpu4 core with idle gaps.
// Define CPU4_SEQ_JUMP_EN to execute JMP (4'hE) inside the sequencer instead of issuing it.
module cpu4_instr_sequencer
   import cpu4_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [11:0] load_data,
   output logic        load_ready,
   input  logic        start,
   input  logic        abort,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [3:0]  issue_opcode,
   output logic [3:0]  issue_addr,
   output logic [3:0]  issue_data,
   output logic        busy,
   output logic        done,
   output logic [3:0]  pc
);

   localparam int          AW       = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
   localparam logic [4:0]  DEPTH_L  = 5'(PROG_DEPTH);
   localparam logic [7:0]  GAP_INIT = (GAP_CYCLES < 1) ? 8'd1 : 8'(GAP_CYCLES);

   seq_state_t  state_q, state_d;
   logic [4:0]  pc_q, pc_d;
   logic [4:0]  len_q, len_d;
   logic [7:0]  gap_q, gap_d;
   logic [11:0] instr_q, instr_d;
   logic [11:0] rd_data;
   logic        wr_en;
   logic        issuing;

   // Read address follows next-state pc so the word is ready during FETCH.
   cpu4_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .AW    (AW)
   ) u_prog_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (len_q[AW-1:0]),
      .wr_data (load_data),
      .rd_addr (pc_d[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         instr_q <= NOP_WORD;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      gap_d   = gap_q;
      instr_d = instr_q;
      wr_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end else if (load_valid && load_ready) begin
               wr_en = 1'b1;
               len_d = len_q + 5'd1;
            end
         end
         S_FETCH: begin
            if (pc_q >= len_q || rd_data[11:8] == OP_HALT) begin
               state_d = S_DONE;
`ifdef CPU4_SEQ_JUMP_EN
            end else if (rd_data[11:8] == OP_JMP) begin
               if ({1'b0, rd_data[7:4]} >= len_q) begin
                  state_d = S_DONE;
               end else begin
                  pc_d = {1'b0, rd_data[7:4]};
               end
`endif
            end else begin
               state_d = S_ISSUE;
               instr_d = rd_data;
            end
         end
         S_ISSUE: begin
            if (issue_ready) begin
               state_d = S_GAP;
               gap_d   = GAP_INIT;
               if (pc_q < len_q) begin
                  pc_d = pc_q + 5'd1;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q <= 8'd1) begin
               state_d = S_FETCH;
               gap_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides every transition above, including an ISSUE handshake.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         pc_d    = pc_q;
         gap_d   = '0;
      end
   end

   assign issuing      = (state_q == S_ISSUE) && !abort;
   assign issue_valid  = issuing;
   assign issue_opcode = issuing ? instr_q[11:8] : OP_HALT;
   assign issue_addr   = issuing ? instr_q[7:4]  : 4'h0;
   assign issue_data   = issuing ? instr_q[3:0]  : 4'h0;
   assign load_ready   = (state_q == S_IDLE) && (len_q < DEPTH_L);
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign pc           = pc_q[4] ? 4'hF : pc_q[3:0];

endmodule
